// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a start/done handshake.
// Optional drop counter (o_ovf_count) enabled by defining UART_TX_FIFO_OVF_CNT_EN.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [7:0]        i_wr_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
`ifdef UART_TX_FIFO_OVF_CNT_EN
  output logic [7:0]        o_ovf_count,
`endif
  output logic              o_tx_start,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_done,
  output logic [1:0]        dbg_state
);

  // Transmitter handshake: o_tx_start is a single-cycle request that latches
  // o_tx_data; the transmitter answers with a single-cycle i_tx_done, which is
  // only honoured while waiting for it. Host writes have no back-pressure.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic [7:0]        tx_data;
  logic              overflow;
  logic              pop, tx_start, wr_accept;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_start  = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        tx_start  = 1'b1;
        state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_tx_done) state_nxt = S_GAP;
      end
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A pop in the same cycle frees the head slot, so a write into a full
  // FIFO is still taken when the FSM is draining it.
  assign wr_accept = i_wr_en && ((count != FULL_CNT) || pop);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_data  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      overflow <= i_wr_en && !wr_accept;
      if (wr_accept) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        tx_data <= mem[rd_ptr];
      end
      case ({wr_accept, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset && wr_accept) mem[wr_ptr] <= i_wr_data;
  end

`ifdef UART_TX_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      ovf_cnt <= 8'h00;
    end else if (i_wr_en && !wr_accept && ovf_cnt != 8'hFF) begin
      ovf_cnt <= ovf_cnt + 8'h01;
    end
  end

  assign o_ovf_count = ovf_cnt;
`endif

  assign o_full     = (count == FULL_CNT);
  assign o_empty    = (count == '0);
  assign o_count    = count;
  assign o_overflow = overflow;
  assign o_tx_start = tx_start;
  assign o_tx_data  = tx_data;
  assign dbg_state  = state;

endmodule
